// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the datapath and the data-memory responder.
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  DataSrc;
    logic [31:0] ReadData;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata, DataSrc,
        input  ReadData, ready, busy, err
    );

    modport slave (
        input  req, we, addr, wdata, DataSrc,
        output ReadData, ready, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time against a byte-lane word RAM with wait states;
// word-crossing accesses are split into two word accesses.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic                 clk,
    input logic                 Reset_n,
    data_mem_responder_if.slave bus
);
    localparam int unsigned   AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned   CW       = 3;
    localparam logic [32:0]   TOP_BYTE = 33'(4 * DEPTH_WORDS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic          NO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACC0, S_ACC1, S_RESP} state_t;

    state_t        state;
    logic          we_q;
    logic          bad_q;
    logic          second_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   lo_q;
    logic [2:0]    code_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   mem [DEPTH_WORDS];

    function automatic logic [2:0] size_bytes(input logic [2:0] code);
        case (code[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] code, input logic [31:0] v);
        case (code[1:0])
            2'b00:   return code[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   return code[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Request legality, evaluated on the live bus while IDLE
    logic        legal_c;
    logic        in_range_c;
    logic [32:0] last_byte_c;

    always_comb begin
        case (bus.DataSrc)
            3'b000, 3'b001, 3'b010: legal_c = 1'b1;
            3'b100, 3'b101:         legal_c = !bus.we;
            default:                legal_c = 1'b0;
        endcase
        last_byte_c = {1'b0, bus.addr} + 33'(size_bytes(bus.DataSrc)) - 33'd1;
        in_range_c  = (last_byte_c <= TOP_BYTE);
    end

    // Two-word lane window: low word is addr[..:2], high word is the next one
    logic [1:0]    lane_c;
    logic [7:0]    base_mask_c;
    logic [7:0]    mask_c;
    logic          split_c;
    logic [63:0]   wide_wd_c;
    logic [63:0]   raw_c;
    logic [31:0]   shifted_c;
    logic [31:0]   load_c;
    logic [AW-1:0] idx0_c;
    logic [AW-1:0] acc_idx_c;
    logic [31:0]   rd_word_c;
    logic          mem_wr_c;
    logic [3:0]    mem_be_c;
    logic [31:0]   mem_wd_c;

    always_comb begin
        lane_c = addr_q[1:0];
        case (code_q[1:0])
            2'b00:   base_mask_c = 8'h01;
            2'b01:   base_mask_c = 8'h03;
            default: base_mask_c = 8'h0F;
        endcase
        mask_c    = base_mask_c << lane_c;
        split_c   = |mask_c[7:4];
        wide_wd_c = {32'h0, wdata_q} << {lane_c, 3'b000};
        idx0_c    = addr_q[AW+1:2];
        acc_idx_c = (state == S_ACC1) ? idx0_c + AW'(1) : idx0_c;
        rd_word_c = mem[acc_idx_c];
        raw_c     = (state == S_ACC1) ? {rd_word_c, lo_q} : {32'h0, rd_word_c};
        shifted_c = 32'(raw_c >> {lane_c, 3'b000});
        load_c    = extend(code_q, shifted_c);
        mem_wr_c  = (state == S_ACC0 || state == S_ACC1) && we_q && !bad_q;
        mem_be_c  = (state == S_ACC1) ? mask_c[7:4] : mask_c[3:0];
        mem_wd_c  = (state == S_ACC1) ? wide_wd_c[63:32] : wide_wd_c[31:0];
    end

    always_ff @(posedge clk) begin
        if (mem_wr_c) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_c[b]) mem[acc_idx_c][8*b +: 8] <= mem_wd_c[8*b +: 8];
            end
        end
    end

    // Rejected requests pass through ACC0 with memory untouched so the error lands one edge after acceptance
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            we_q         <= 1'b0;
            bad_q        <= 1'b0;
            second_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            code_q       <= '0;
            cnt_q        <= '0;
            bus.ReadData <= '0;
            bus.ready    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        we_q     <= bus.we;
                        addr_q   <= bus.addr[AW+1:0];
                        wdata_q  <= bus.wdata;
                        code_q   <= bus.DataSrc;
                        bad_q    <= !(legal_c && in_range_c);
                        second_q <= 1'b0;
                        cnt_q    <= CNT_LOAD;
                        bus.busy <= 1'b1;
                        bus.err  <= 1'b0;
                        state    <= (NO_WAIT || !(legal_c && in_range_c)) ? S_ACC0 : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) state <= second_q ? S_ACC1 : S_ACC0;
                    else             cnt_q <= cnt_q - CW'(1);
                end
                S_ACC0: begin
                    if (bad_q) begin
                        bus.ReadData <= '0;
                        bus.err      <= 1'b1;
                        bus.ready    <= 1'b1;
                        state        <= S_RESP;
                    end else if (split_c) begin
                        second_q <= 1'b1;
                        lo_q     <= rd_word_c;
                        cnt_q    <= CNT_LOAD;
                        state    <= NO_WAIT ? S_ACC1 : S_WAIT;
                    end else begin
                        if (!we_q) bus.ReadData <= load_c;
                        bus.ready <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_ACC1: begin
                    if (!we_q) bus.ReadData <= load_c;
                    bus.ready <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset-abort sequences, wait-state sweep and
// randomized accesses checked against a byte-array model.
module tb_data_mem_responder;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int NI = 3;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;
        logic        e;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    logic        clk;
    logic        Reset_n;
    logic [2:0]  req_v;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  code;
    int          sel;
    logic        o_ready, o_busy, o_err;
    logic [31:0] o_rd;

    int          errors = 0;
    int          checks = 0;
    int          wv [NI] = '{1, 0, 7};
    logic [2:0]  lc [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [7:0]  mm [NI][1024];
    logic [31:0] last_rd [NI];
    vec_t        tbl [$];

    data_mem_responder_if b0 ();
    data_mem_responder_if b1 ();
    data_mem_responder_if b2 ();

    assign b0.req = req_v[0]; assign b0.we = we; assign b0.addr = addr; assign b0.wdata = wdata; assign b0.DataSrc = code;
    assign b1.req = req_v[1]; assign b1.we = we; assign b1.addr = addr; assign b1.wdata = wdata; assign b1.DataSrc = code;
    assign b2.req = req_v[2]; assign b2.we = we; assign b2.addr = addr; assign b2.wdata = wdata; assign b2.DataSrc = code;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u0 (.clk(clk), .Reset_n(Reset_n), .bus(b0));
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u1 (.clk(clk), .Reset_n(Reset_n), .bus(b1));
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(7)) u2 (.clk(clk), .Reset_n(Reset_n), .bus(b2));

    assign o_ready = (sel == 0) ? b0.ready    : (sel == 1) ? b1.ready    : b2.ready;
    assign o_busy  = (sel == 0) ? b0.busy     : (sel == 1) ? b1.busy     : b2.busy;
    assign o_err   = (sel == 0) ? b0.err      : (sel == 1) ? b1.err      : b2.err;
    assign o_rd    = (sel == 0) ? b0.ReadData : (sel == 1) ? b1.ReadData : b2.ReadData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                                input logic e, input logic [31:0] rd, input int lat);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.c = c; v.e = e; v.rd = rd; v.lat = lat;
        return v;
    endfunction

    // Behavioural reference: byte-addressed memory, latency from the wait-state rule
    function automatic void model(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] c, output logic e, output logic [31:0] rd, output int lat);
        int          n;
        logic        legal;
        longint      last;
        logic [31:0] v;
        n     = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
        legal = w ? (c <= 3'd2) : (c <= 3'd2 || c == 3'd4 || c == 3'd5);
        last  = longint'({32'h0, a}) + longint'(n) - 1;
        if (!legal || last > 1023) begin
            e = 1'b1; rd = '0; lat = 1; last_rd[s] = '0;
            return;
        end
        e   = 1'b0;
        lat = ((int'(a[1:0]) + n) > 4) ? 2 * wv[s] + 2 : wv[s] + 1;
        if (w) begin
            for (int i = 0; i < n; i++) mm[s][int'(a[9:0]) + i] = d[8*i +: 8];
            rd = last_rd[s];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mm[s][int'(a[9:0]) + i];
            if (!c[2] && n == 1)      v = {{24{v[7]}}, v[7:0]};
            else if (!c[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
            last_rd[s] = v;
        end
    endfunction

    task automatic do_access(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] c, output logic e, output logic [31:0] rd, output int lat);
        @(negedge clk);
        sel = s; we = w; addr = a; wdata = d; code = c;
        req_v = 3'b000; req_v[s] = 1'b1;
        @(posedge clk); #1;
        req_v = 3'b000; we = 1'($urandom); addr = $urandom; wdata = $urandom; code = 3'($urandom);
        chk($sformatf("busy after accept inst%0d", s), 32'(o_busy), 32'd1);
        lat = -1; e = 1'b0; rd = '0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (o_ready) begin lat = k; e = o_err; rd = o_rd; end
        end
        if (lat < 0) begin
            chk($sformatf("ready timeout inst%0d a=%h", s, a), 32'(o_ready), 32'd1);
        end else begin
            chk($sformatf("busy in ready cycle inst%0d", s), 32'(o_busy), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("ready one-cycle inst%0d", s), 32'(o_ready), 32'd0);
            chk($sformatf("busy after ready inst%0d", s), 32'(o_busy), 32'd0);
        end
    endtask

    task automatic run(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] c, output logic [31:0] got);
        logic        ee, ge;
        logic [31:0] er;
        int          el, gl;
        model(s, w, a, d, c, ee, er, el);
        do_access(s, w, a, d, c, ge, got, gl);
        chk($sformatf("err inst%0d we=%0b a=%h c=%0d", s, w, a, c), 32'(ge), 32'(ee));
        chk($sformatf("rdata inst%0d we=%0b a=%h c=%0d", s, w, a, c), got, er);
        chk($sformatf("latency inst%0d we=%0b a=%h c=%0d", s, w, a, c), 32'(gl), 32'(el));
    endtask

    task automatic reset_during(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] c, input int edges);
        @(negedge clk);
        sel = s; we = w; addr = a; wdata = d; code = c;
        req_v = 3'b000; req_v[s] = 1'b1;
        @(posedge clk); #1;
        req_v = 3'b000;
        repeat (edges) begin @(posedge clk); #1; end
        chk("busy before reset", 32'(o_busy), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("ready in reset", 32'(o_ready), 32'd0);
        chk("busy in reset", 32'(o_busy), 32'd0);
        chk("err in reset", 32'(o_err), 32'd0);
        chk("rdata in reset", o_rd, 32'd0);
        @(negedge clk);
        Reset_n = 1'b1;
        for (int i = 0; i < NI; i++) last_rd[i] = '0;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] last_tbl;
        logic [31:0] exp_rd;
        logic        ge, me;
        logic [31:0] mr;
        int          gl, ml;

        Reset_n = 1'b0; req_v = 3'b000; we = 1'b0; addr = '0; wdata = '0; code = '0; sel = 0;
        for (int i = 0; i < NI; i++) last_rd[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < NI; s++) begin
            sel = s; #1;
            chk($sformatf("reset ready inst%0d", s), 32'(o_ready), 32'd0);
            chk($sformatf("reset busy inst%0d", s), 32'(o_busy), 32'd0);
            chk($sformatf("reset err inst%0d", s), 32'(o_err), 32'd0);
            chk($sformatf("reset rdata inst%0d", s), o_rd, 32'd0);
        end
        @(negedge clk);
        Reset_n = 1'b1;

        // Directed table on the one-wait-state instance: single=2, split=4, error=1 edges after acceptance
        tbl.push_back(mk(1, 32'h010, 32'h12345678, 3'd2, 0, 32'h0,        2));
        tbl.push_back(mk(0, 32'h010, 32'h0,        3'd2, 0, 32'h12345678, 2));
        tbl.push_back(mk(1, 32'h000, 32'h00000830, 3'd2, 0, 32'h0,        2));
        tbl.push_back(mk(0, 32'h000, 32'h0,        3'd0, 0, 32'h00000030, 2));
        tbl.push_back(mk(1, 32'h020, 32'h11223344, 3'd2, 0, 32'h0,        2));
        tbl.push_back(mk(1, 32'h021, 32'hDEADBE83, 3'd0, 0, 32'h0,        2));
        tbl.push_back(mk(0, 32'h021, 32'h0,        3'd0, 0, 32'hFFFFFF83, 2));
        tbl.push_back(mk(0, 32'h021, 32'h0,        3'd4, 0, 32'h00000083, 2));
        tbl.push_back(mk(0, 32'h020, 32'h0,        3'd2, 0, 32'h11228344, 2));
        tbl.push_back(mk(1, 32'h004, 32'h0,        3'd2, 0, 32'h0,        2));
        tbl.push_back(mk(1, 32'h008, 32'h0,        3'd2, 0, 32'h0,        2));
        tbl.push_back(mk(1, 32'h006, 32'hAABBCCDD, 3'd2, 0, 32'h0,        4));
        tbl.push_back(mk(0, 32'h004, 32'h0,        3'd2, 0, 32'hCCDD0000, 2));
        tbl.push_back(mk(0, 32'h008, 32'h0,        3'd2, 0, 32'h0000AABB, 2));
        tbl.push_back(mk(0, 32'h006, 32'h0,        3'd2, 0, 32'hAABBCCDD, 4));
        tbl.push_back(mk(0, 32'h007, 32'h0,        3'd1, 0, 32'hFFFFBBCC, 4));
        tbl.push_back(mk(0, 32'h007, 32'h0,        3'd5, 0, 32'h0000BBCC, 4));
        tbl.push_back(mk(0, 32'h006, 32'h0,        3'd1, 0, 32'hFFFFCCDD, 2));
        tbl.push_back(mk(0, 32'h400, 32'h0,        3'd2, 1, 32'h0,        1));
        tbl.push_back(mk(0, 32'h010, 32'h0,        3'd3, 1, 32'h0,        1));
        tbl.push_back(mk(1, 32'h010, 32'hFFFFFFFF, 3'd4, 1, 32'h0,        1));
        tbl.push_back(mk(0, 32'h010, 32'h0,        3'd2, 0, 32'h12345678, 2));
        tbl.push_back(mk(1, 32'h3FC, 32'hCAFEF00D, 3'd2, 0, 32'h0,        2));
        tbl.push_back(mk(1, 32'h3FE, 32'h12345678, 3'd2, 1, 32'h0,        1));
        tbl.push_back(mk(0, 32'h3FC, 32'h0,        3'd2, 0, 32'hCAFEF00D, 2));
        tbl.push_back(mk(0, 32'h3FF, 32'h0,        3'd0, 0, 32'hFFFFFFCA, 2));
        tbl.push_back(mk(0, 32'h3FF, 32'h0,        3'd1, 1, 32'h0,        1));
        tbl.push_back(mk(0, 32'h3FE, 32'h0,        3'd5, 0, 32'h0000CAFE, 2));
        tbl.push_back(mk(1, 32'h030, 32'h0BADF00D, 3'd2, 0, 32'h0,        2));
        tbl.push_back(mk(1, 32'h034, 32'h01020304, 3'd2, 0, 32'h0,        2));

        last_tbl = '0;
        foreach (tbl[i]) begin
            model(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].c, me, mr, ml);
            do_access(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].c, ge, got, gl);
            exp_rd   = (tbl[i].w && !tbl[i].e) ? last_tbl : tbl[i].rd;
            last_tbl = exp_rd;
            chk($sformatf("vec%0d err", i), 32'(ge), 32'(tbl[i].e));
            chk($sformatf("vec%0d rdata", i), got, exp_rd);
            chk($sformatf("vec%0d latency", i), 32'(gl), 32'(tbl[i].lat));
        end

        // Reset while a store waits: nothing written
        reset_during(0, 1'b1, 32'h030, 32'h00000055, 3'd2, 0);
        run(0, 1'b0, 32'h030, 32'h0, 3'd2, got);
        chk("old value after aborted store", got, 32'h0BADF00D);

        // Reset between the two halves of a split store: first word keeps its half
        reset_during(0, 1'b1, 32'h032, 32'hA1B2C3D4, 3'd2, 2);
        mm[0][32'h32] = 8'hD4;
        mm[0][32'h33] = 8'hC3;
        run(0, 1'b0, 32'h030, 32'h0, 3'd2, got);
        chk("first word partially written", got, 32'hC3D4F00D);
        run(0, 1'b0, 32'h034, 32'h0, 3'd2, got);
        chk("second word untouched", got, 32'h01020304);

        // Zero wait states
        run(1, 1'b1, 32'h040, 32'h89ABCDEF, 3'd2, got);
        run(1, 1'b0, 32'h040, 32'h0, 3'd2, got);
        chk("W0 lw data", got, 32'h89ABCDEF);
        run(1, 1'b1, 32'h045, 32'h13572468, 3'd2, got);
        run(1, 1'b0, 32'h045, 32'h0, 3'd2, got);
        chk("W0 split lw data", got, 32'h13572468);
        run(1, 1'b0, 32'h047, 32'h0, 3'd5, got);
        chk("W0 split lhu data", got, 32'h00001357);

        // Seven wait states
        run(2, 1'b1, 32'h080, 32'h7F00FF01, 3'd2, got);
        run(2, 1'b0, 32'h080, 32'h0, 3'd2, got);
        chk("W7 lw data", got, 32'h7F00FF01);
        run(2, 1'b0, 32'h081, 32'h0, 3'd0, got);
        chk("W7 lb data", got, 32'hFFFFFFFF);
        run(2, 1'b1, 32'h083, 32'hDEADBEEF, 3'd2, got);
        run(2, 1'b0, 32'h083, 32'h0, 3'd2, got);
        chk("W7 split lw data", got, 32'hDEADBEEF);
        run(2, 1'b0, 32'h400, 32'h0, 3'd2, got);

        // Fill the whole RAM so every later load has a known model value
        for (int a = 0; a < 1024; a += 4) run(0, 1'b1, 32'(a), $urandom, 3'd2, got);

        for (int i = 0; i < 300; i++) begin
            logic        w;
            logic [2:0]  c;
            logic [31:0] a;
            int          pick;
            w    = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            c    = (pick == 0) ? 3'($urandom) : lc[$urandom_range(0, 4)];
            pick = $urandom_range(0, 15);
            if (pick == 0)     a = $urandom;
            else if (pick < 3) a = 32'($urandom_range(1008, 1039));
            else               a = 32'($urandom_range(0, 1023));
            run(0, w, a, $urandom, c, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
